aes_ctr_keystream: RTL

//  Upstream controller and downstream consumer for the AES encipher core in CTR mode.
//  - Holds a 128-bit counter block and drives it, with a next pulse, into the encipher core.
//  - Captures the resulting keystream block.
//  - XORs the keystream with streamed 128-bit data on valid/ready interfaces.
//  - Sits between the DMA/packet datapath and the encipher core; round keys come from the key expansion logic.

---
 rtl/aes_ctr_keystream_if.sv | 27 ++
 rtl/aes_ctr_keystream.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_keystream_if.sv
// Stream and encipher-core signal bundle for aes_ctr_keystream.
// master: the keystream block; slave: the data source/sink and encipher core side.
interface aes_ctr_keystream_if;
   logic [127:0] s_data;
   logic         s_last;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] m_data;
   logic         m_last;
   logic         m_valid;
   logic         m_ready;
   logic         enc_keylen;
   logic         enc_next;
   logic [127:0] enc_block;
   logic         enc_ready;
   logic [127:0] enc_result;

   modport master (
      input  s_data, s_last, s_valid, m_ready, enc_ready, enc_result,
      output s_ready, m_data, m_last, m_valid, enc_keylen, enc_next, enc_block
   );

   modport slave (
      output s_data, s_last, s_valid, m_ready, enc_ready, enc_result,
      input  s_ready, m_data, m_last, m_valid, enc_keylen, enc_next, enc_block
   );
endinterface

// File: rtl/aes_ctr_keystream.sv
// AES-CTR keystream sequencer: issues counter blocks to the encipher core, buffers the
// keystream and XORs it onto the data stream. AES_CTR_PREFETCH2_EN selects a 2-entry buffer.
module aes_ctr_keystream #(
   parameter int unsigned CTR_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 keylen,
   input  logic [127:0]         ctr_init,
   input  logic                 ctr_load,
   aes_ctr_keystream_if.master  bus,
   output logic [127:0]         ctr_value,
   output logic                 busy
);

   localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;
`ifdef AES_CTR_PREFETCH2_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   typedef enum logic [1:0] {CTRL_IDLE, CTRL_ISSUE, CTRL_WAIT} ctrl_e;

   ctrl_e        state_q, state_d;
   logic         loaded_q, loaded_d;
   logic         first_q, first_d;
   logic         discard_q, discard_d;
   logic         enc_next_q, enc_next_d;
   logic         busy_q, busy_d;
   logic [127:0] ctr_value_q, ctr_value_d;
   logic [127:0] enc_block_q, enc_block_d;
   logic [127:0] m_data_q, m_data_d;
   logic         m_last_q, m_last_d;
   logic         m_valid_q, m_valid_d;
   logic [127:0] ks0_q, ks0_d;
`ifdef AES_CTR_PREFETCH2_EN
   logic [127:0] ks1_q, ks1_d;
`endif
   logic [1:0]   count_q, count_d;
   logic         s_ready_c, accept, capture;

   // Block counter and enc_block are latched on the way into ISSUE so enc_block is valid
   // in the same cycle as enc_next.
   always_comb begin
      state_d     = state_q;
      loaded_d    = loaded_q;
      first_d     = first_q;
      discard_d   = discard_q;
      ctr_value_d = ctr_value_q;
      enc_block_d = enc_block_q;
      capture     = 1'b0;
      if (ctr_load) begin
         loaded_d    = 1'b1;
         ctr_value_d = ctr_init;
         if (state_q != CTRL_IDLE) discard_d = 1'b1;
      end
      unique case (state_q)
         CTRL_IDLE: begin
            if (loaded_q && count_q != DEPTH && bus.enc_ready && !ctr_load) begin
               state_d     = CTRL_ISSUE;
               enc_block_d = ctr_value_q;
               ctr_value_d = ((ctr_value_q + 128'd1) & CTR_MASK) | (ctr_value_q & ~CTR_MASK);
            end
         end
         CTRL_ISSUE: begin
            state_d = CTRL_WAIT;
            first_d = 1'b1;
         end
         CTRL_WAIT: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (bus.enc_ready) begin
               // A load landing on the completion cycle also invalidates this result.
               capture   = !discard_q && !ctr_load;
               discard_d = 1'b0;
               state_d   = CTRL_IDLE;
            end
         end
         default: state_d = CTRL_IDLE;
      endcase
      enc_next_d = (state_d == CTRL_ISSUE);
      busy_d     = (state_d != CTRL_IDLE);
   end

   always_comb begin
      s_ready_c = !reset && !ctr_load && count_q != 2'd0 && (!m_valid_q || bus.m_ready);
      accept    = s_ready_c && bus.s_valid;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      if (accept) begin
         m_data_d  = bus.s_data ^ ks0_q;
         m_last_d  = bus.s_last;
         m_valid_d = 1'b1;
      end else if (bus.m_ready) begin
         m_valid_d = 1'b0;
      end
   end

`ifdef AES_CTR_PREFETCH2_EN
   always_comb begin
      ks0_d   = ks0_q;
      ks1_d   = ks1_q;
      count_d = count_q;
      if (ctr_load) begin
         count_d = '0;
      end else begin
         if (accept) ks0_d = ks1_q;
         // Write lands in the slot left free after any simultaneous pop.
         if (capture) begin
            if (count_q - 2'(accept) == 2'd0) ks0_d = bus.enc_result;
            else                              ks1_d = bus.enc_result;
         end
         count_d = count_q + 2'(capture) - 2'(accept);
      end
   end
`else
   always_comb begin
      ks0_d   = ks0_q;
      count_d = count_q;
      if (ctr_load) begin
         count_d = '0;
      end else begin
         if (capture) ks0_d = bus.enc_result;
         count_d = count_q + 2'(capture) - 2'(accept);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CTRL_IDLE;
         loaded_q    <= 1'b0;
         first_q     <= 1'b0;
         discard_q   <= 1'b0;
         enc_next_q  <= 1'b0;
         busy_q      <= 1'b0;
         ctr_value_q <= '0;
         enc_block_q <= '0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         ks0_q       <= '0;
`ifdef AES_CTR_PREFETCH2_EN
         ks1_q       <= '0;
`endif
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         loaded_q    <= loaded_d;
         first_q     <= first_d;
         discard_q   <= discard_d;
         enc_next_q  <= enc_next_d;
         busy_q      <= busy_d;
         ctr_value_q <= ctr_value_d;
         enc_block_q <= enc_block_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
         m_valid_q   <= m_valid_d;
         ks0_q       <= ks0_d;
`ifdef AES_CTR_PREFETCH2_EN
         ks1_q       <= ks1_d;
`endif
         count_q     <= count_d;
      end
   end

   assign bus.s_ready    = s_ready_c;
   assign bus.m_data     = m_data_q;
   assign bus.m_last     = m_last_q;
   assign bus.m_valid    = m_valid_q;
   assign bus.enc_keylen = keylen;
   assign bus.enc_next   = enc_next_q;
   assign bus.enc_block  = enc_block_q;
   assign ctr_value      = ctr_value_q;
   assign busy           = busy_q;

endmodule
